// File: rtl/riscv_mem_arbiter_if.sv
// Cache-side request bundle and shared memory line port of riscv_mem_arbiter.
// slave = arbiter view, master = requesters plus memory controller (bench/SoC view).
interface riscv_mem_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 128
);
  logic [NUM_CH-1:0]        i_riscv_arb_req;
  logic [NUM_CH-1:0]        i_riscv_arb_we;
  logic [NUM_CH*ADDR_W-1:0] i_riscv_arb_addr;
  logic [NUM_CH*LINE_W-1:0] i_riscv_arb_wdata;
  logic [NUM_CH-1:0]        o_riscv_arb_ack;
  logic [LINE_W-1:0]        o_riscv_arb_rdata;
  logic                     o_riscv_arb_busy;
  logic                     o_riscv_arb_mem_req;
  logic                     o_riscv_arb_mem_we;
  logic [ADDR_W-1:0]        o_riscv_arb_mem_addr;
  logic [LINE_W-1:0]        o_riscv_arb_mem_wdata;
  logic                     i_riscv_arb_mem_ready;
  logic [LINE_W-1:0]        i_riscv_arb_mem_rdata;

  modport slave (
    input  i_riscv_arb_req, i_riscv_arb_we, i_riscv_arb_addr, i_riscv_arb_wdata,
    input  i_riscv_arb_mem_ready, i_riscv_arb_mem_rdata,
    output o_riscv_arb_ack, o_riscv_arb_rdata, o_riscv_arb_busy,
    output o_riscv_arb_mem_req, o_riscv_arb_mem_we, o_riscv_arb_mem_addr, o_riscv_arb_mem_wdata
  );

  modport master (
    output i_riscv_arb_req, i_riscv_arb_we, i_riscv_arb_addr, i_riscv_arb_wdata,
    output i_riscv_arb_mem_ready, i_riscv_arb_mem_rdata,
    input  o_riscv_arb_ack, o_riscv_arb_rdata, o_riscv_arb_busy,
    input  o_riscv_arb_mem_req, o_riscv_arb_mem_we, o_riscv_arb_mem_addr, o_riscv_arb_mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// N-channel cache-to-memory line arbiter: one transaction at a time,
// fixed-priority or round-robin grant, registered outputs throughout.
module riscv_mem_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned RR_EN  = 1
) (
  input logic                i_riscv_arb_clk,
  input logic                i_riscv_arb_rst,
  riscv_mem_arbiter_if.slave bus
);
  localparam int unsigned      IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    owner_q;
  logic [NUM_CH-1:0]   ack_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                busy_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;

  logic [IDX_W-1:0]    start_c;
  logic [IDX_W-1:0]    scan_c;
  logic [IDX_W-1:0]    grant_idx_c;
  logic                grant_vld_c;
  logic                sel_we_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [LINE_W-1:0]   sel_wdata_c;
  logic [NUM_CH-1:0]   owner_oh_c;

  // Winner search: ascending from the pointer (or from 0 in fixed priority), wrapping.
  always_comb begin
    start_c     = (RR_EN != 0) ? ptr_q : '0;
    scan_c      = start_c;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_vld_c && bus.i_riscv_arb_req[scan_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = scan_c;
      end
      scan_c = (scan_c == LAST_CH) ? '0 : scan_c + IDX_W'(1);
    end
  end

  // Select the winner's payload and decode the current owner to one-hot.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    owner_oh_c  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_idx_c == IDX_W'(k)) begin
        sel_we_c    = bus.i_riscv_arb_we[k];
        sel_addr_c  = bus.i_riscv_arb_addr[k*ADDR_W +: ADDR_W];
        sel_wdata_c = bus.i_riscv_arb_wdata[k*LINE_W +: LINE_W];
      end
      if (owner_q == IDX_W'(k)) owner_oh_c[k] = 1'b1;
    end
  end

  // ack is raised on the BUSY->DONE edge so that it is visible during DONE.
  always_ff @(posedge i_riscv_arb_clk) begin
    if (!i_riscv_arb_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld_c) begin
            owner_q     <= grant_idx_c;
            mem_we_q    <= sel_we_c;
            mem_addr_q  <= sel_addr_c;
            mem_wdata_q <= sel_wdata_c;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.i_riscv_arb_mem_ready) begin
            if (!mem_we_q) rdata_q <= bus.i_riscv_arb_mem_rdata;
            ack_q     <= owner_oh_c;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= (owner_q == LAST_CH) ? '0 : owner_q + IDX_W'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_riscv_arb_ack       = ack_q;
  assign bus.o_riscv_arb_rdata     = rdata_q;
  assign bus.o_riscv_arb_busy      = busy_q;
  assign bus.o_riscv_arb_mem_req   = mem_req_q;
  assign bus.o_riscv_arb_mem_we    = mem_we_q;
  assign bus.o_riscv_arb_mem_addr  = mem_addr_q;
  assign bus.o_riscv_arb_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter and a 4-channel round-robin one.
module tb_riscv_mem_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned LW = 128;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  riscv_mem_arbiter_if #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW)) b2 ();
  riscv_mem_arbiter_if #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW)) b4 ();

  riscv_mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW), .RR_EN(0)) dut2 (
    .i_riscv_arb_clk(clk), .i_riscv_arb_rst(rst), .bus(b2.slave));
  riscv_mem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1)) dut4 (
    .i_riscv_arb_clk(clk), .i_riscv_arb_rst(rst), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (b2.o_riscv_arb_mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b exp 0", b2.o_riscv_arb_mem_req); else passed++;
    total++; if (b2.o_riscv_arb_busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", b2.o_riscv_arb_busy); else passed++;
    total++; if (b2.o_riscv_arb_ack !== 2'b00) $display("FAIL rst_ack: got %b exp 00", b2.o_riscv_arb_ack); else passed++;
    total++; if (b2.o_riscv_arb_rdata !== '0) $display("FAIL rst_rdata: got %h exp 0", b2.o_riscv_arb_rdata); else passed++;
    total++; if (b2.o_riscv_arb_mem_addr !== '0 || b2.o_riscv_arb_mem_we !== 1'b0 || b2.o_riscv_arb_mem_wdata !== '0)
      $display("FAIL rst_mem_bus: got addr %h we %b wdata %h exp all 0", b2.o_riscv_arb_mem_addr, b2.o_riscv_arb_mem_we, b2.o_riscv_arb_mem_wdata);
    else passed++;
    total++; if (b4.o_riscv_arb_mem_req !== 1'b0 || b4.o_riscv_arb_ack !== 4'b0) $display("FAIL rst_dut4: got req %b ack %b exp 0/0000", b4.o_riscv_arb_mem_req, b4.o_riscv_arb_ack); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    logic [LW-1:0] rd;
    rd = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    b2.i_riscv_arb_addr = {64'h80, 64'h40};
    b2.i_riscv_arb_we   = 2'b00;
    b2.i_riscv_arb_req  = 2'b10;
    tick();
    total++; if (b2.o_riscv_arb_mem_req !== 1'b1 || b2.o_riscv_arb_busy !== 1'b1) $display("FAIL rd_issue: got req %b busy %b exp 1/1", b2.o_riscv_arb_mem_req, b2.o_riscv_arb_busy); else passed++;
    total++; if (b2.o_riscv_arb_mem_addr !== 64'h80 || b2.o_riscv_arb_mem_we !== 1'b0) $display("FAIL rd_addr: got %h we %b exp 80 we 0", b2.o_riscv_arb_mem_addr, b2.o_riscv_arb_mem_we); else passed++;
    tick();
    tick();
    tick();
    total++; if (b2.o_riscv_arb_mem_req !== 1'b1 || b2.o_riscv_arb_ack !== 2'b00) $display("FAIL rd_wait: got req %b ack %b exp 1/00", b2.o_riscv_arb_mem_req, b2.o_riscv_arb_ack); else passed++;
    b2.i_riscv_arb_mem_ready = 1'b1;
    b2.i_riscv_arb_mem_rdata = rd;
    tick();
    b2.i_riscv_arb_mem_ready = 1'b0;
    b2.i_riscv_arb_mem_rdata = '0;
    total++; if (b2.o_riscv_arb_ack !== 2'b10) $display("FAIL rd_ack: got %b exp 10", b2.o_riscv_arb_ack); else passed++;
    total++; if (b2.o_riscv_arb_rdata !== rd) $display("FAIL rd_data: got %h exp %h", b2.o_riscv_arb_rdata, rd); else passed++;
    total++; if (b2.o_riscv_arb_mem_req !== 1'b0 || b2.o_riscv_arb_busy !== 1'b1) $display("FAIL rd_done: got req %b busy %b exp 0/1", b2.o_riscv_arb_mem_req, b2.o_riscv_arb_busy); else passed++;
    b2.i_riscv_arb_req = 2'b00;
    tick();
    total++; if (b2.o_riscv_arb_ack !== 2'b00 || b2.o_riscv_arb_busy !== 1'b0) $display("FAIL rd_idle: got ack %b busy %b exp 00/0", b2.o_riscv_arb_ack, b2.o_riscv_arb_busy); else passed++;
  endtask

  task automatic test_write();
    logic [LW-1:0] wd;
    logic [LW-1:0] prev;
    wd   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    prev = b2.o_riscv_arb_rdata;
    b2.i_riscv_arb_wdata = {128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, wd};
    b2.i_riscv_arb_we    = 2'b01;
    b2.i_riscv_arb_req   = 2'b01;
    tick();
    total++; if (b2.o_riscv_arb_mem_we !== 1'b1 || b2.o_riscv_arb_mem_addr !== 64'h40) $display("FAIL wr_issue: got we %b addr %h exp 1/40", b2.o_riscv_arb_mem_we, b2.o_riscv_arb_mem_addr); else passed++;
    total++; if (b2.o_riscv_arb_mem_wdata !== wd) $display("FAIL wr_wdata: got %h exp %h", b2.o_riscv_arb_mem_wdata, wd); else passed++;
    b2.i_riscv_arb_mem_ready = 1'b1;
    b2.i_riscv_arb_mem_rdata = '1;
    tick();
    b2.i_riscv_arb_mem_ready = 1'b0;
    b2.i_riscv_arb_req = 2'b00;
    b2.i_riscv_arb_we  = 2'b00;
    total++; if (b2.o_riscv_arb_ack !== 2'b01) $display("FAIL wr_ack: got %b exp 01", b2.o_riscv_arb_ack); else passed++;
    total++; if (b2.o_riscv_arb_rdata !== prev) $display("FAIL wr_rdata_kept: got %h exp %h", b2.o_riscv_arb_rdata, prev); else passed++;
    tick();
    b2.i_riscv_arb_mem_rdata = '0;
  endtask

  task automatic test_fixed_priority();
    b2.i_riscv_arb_addr = {64'h200, 64'h100};
    b2.i_riscv_arb_req  = 2'b11;
    b2.i_riscv_arb_mem_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      total++; if (b2.o_riscv_arb_mem_addr !== 64'h100) $display("FAIL fp_grant%0d: got addr %h exp 100", t, b2.o_riscv_arb_mem_addr); else passed++;
      tick();
      total++; if (b2.o_riscv_arb_ack !== 2'b01) $display("FAIL fp_ack%0d: got %b exp 01", t, b2.o_riscv_arb_ack); else passed++;
      tick();
      total++; if (b2.o_riscv_arb_ack !== 2'b00 || b2.o_riscv_arb_busy !== 1'b0) $display("FAIL fp_gap%0d: got ack %b busy %b exp 00/0", t, b2.o_riscv_arb_ack, b2.o_riscv_arb_busy); else passed++;
    end
    b2.i_riscv_arb_req = 2'b10;
    tick();
    total++; if (b2.o_riscv_arb_mem_addr !== 64'h200) $display("FAIL fp_ch1: got addr %h exp 200", b2.o_riscv_arb_mem_addr); else passed++;
    tick();
    total++; if (b2.o_riscv_arb_ack !== 2'b10) $display("FAIL fp_ch1_ack: got %b exp 10", b2.o_riscv_arb_ack); else passed++;
    b2.i_riscv_arb_req = 2'b00;
    b2.i_riscv_arb_mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_ch;
    logic [3:0] exp_ack;
    b4.i_riscv_arb_addr = {64'h10C0, 64'h1080, 64'h1040, 64'h1000};
    b4.i_riscv_arb_req  = 4'b1111;
    b4.i_riscv_arb_mem_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      exp_ch  = t % 4;
      exp_ack = 4'b0001 << exp_ch;
      tick();
      total++; if (b4.o_riscv_arb_mem_addr !== 64'h1000 + 64'(exp_ch) * 64'h40) $display("FAIL rr_grant%0d: got addr %h exp ch%0d", t, b4.o_riscv_arb_mem_addr, exp_ch); else passed++;
      tick();
      total++; if (b4.o_riscv_arb_ack !== exp_ack) $display("FAIL rr_ack%0d: got %b exp %b", t, b4.o_riscv_arb_ack, exp_ack); else passed++;
      tick();
    end
    b4.i_riscv_arb_req = 4'b0000;
    b4.i_riscv_arb_mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    b4.i_riscv_arb_req = 4'b1001;
    tick();
    total++; if (b4.o_riscv_arb_mem_req !== 1'b1 || b4.o_riscv_arb_mem_addr !== 64'h10C0) $display("FAIL rm_pre: got req %b addr %h exp 1/10c0", b4.o_riscv_arb_mem_req, b4.o_riscv_arb_mem_addr); else passed++;
    rst = 1'b0;
    tick();
    total++; if (b4.o_riscv_arb_mem_req !== 1'b0 || b4.o_riscv_arb_busy !== 1'b0 || b4.o_riscv_arb_ack !== 4'b0)
      $display("FAIL rm_abort: got req %b busy %b ack %b exp 0/0/0000", b4.o_riscv_arb_mem_req, b4.o_riscv_arb_busy, b4.o_riscv_arb_ack);
    else passed++;
    tick();
    total++; if (b4.o_riscv_arb_mem_req !== 1'b0 || b4.o_riscv_arb_ack !== 4'b0) $display("FAIL rm_hold: got req %b ack %b exp 0/0000", b4.o_riscv_arb_mem_req, b4.o_riscv_arb_ack); else passed++;
    rst = 1'b1;
    tick();
    total++; if (b4.o_riscv_arb_mem_req !== 1'b1 || b4.o_riscv_arb_mem_addr !== 64'h1000) $display("FAIL rm_rearb: got req %b addr %h exp 1/1000", b4.o_riscv_arb_mem_req, b4.o_riscv_arb_mem_addr); else passed++;
    b4.i_riscv_arb_mem_ready = 1'b1;
    tick();
    total++; if (b4.o_riscv_arb_ack !== 4'b0001) $display("FAIL rm_ack: got %b exp 0001", b4.o_riscv_arb_ack); else passed++;
    b4.i_riscv_arb_req = 4'b0000;
    b4.i_riscv_arb_mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_stray_ready();
    logic [LW-1:0] prev;
    prev = b2.o_riscv_arb_rdata;
    b2.i_riscv_arb_req = 2'b00;
    b2.i_riscv_arb_mem_ready = 1'b1;
    b2.i_riscv_arb_mem_rdata = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    tick();
    tick();
    total++; if (b2.o_riscv_arb_ack !== 2'b00 || b2.o_riscv_arb_busy !== 1'b0 || b2.o_riscv_arb_mem_req !== 1'b0)
      $display("FAIL stray_state: got ack %b busy %b req %b exp 00/0/0", b2.o_riscv_arb_ack, b2.o_riscv_arb_busy, b2.o_riscv_arb_mem_req);
    else passed++;
    total++; if (b2.o_riscv_arb_rdata !== prev) $display("FAIL stray_rdata: got %h exp %h", b2.o_riscv_arb_rdata, prev); else passed++;
    b2.i_riscv_arb_mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    b2.i_riscv_arb_req = '0;  b2.i_riscv_arb_we = '0;  b2.i_riscv_arb_addr = '0;  b2.i_riscv_arb_wdata = '0;
    b2.i_riscv_arb_mem_ready = 1'b0;  b2.i_riscv_arb_mem_rdata = '0;
    b4.i_riscv_arb_req = '0;  b4.i_riscv_arb_we = '0;  b4.i_riscv_arb_addr = '0;  b4.i_riscv_arb_wdata = '0;
    b4.i_riscv_arb_mem_ready = 1'b0;  b4.i_riscv_arb_mem_rdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid_busy();
    test_stray_ready();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Parametrised N-channel arbiter between the core-side caches (instruction cache, data cache, future MMU walker) and a single shared main-memory line port. It serialises cache line refill and writeback transactions and issues one at a time to memory. It supports fixed-priority or round-robin selection and returns the read line with a per-channel acknowledge. It sits in the SoC top between the cache instances and the memory controller.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels (≥2); channel 0 = instruction cache, channel 1 = data cache by convention.
- ADDR_W, 64: physical line address width.
- LINE_W, 128: cache line width in bits.
- RR_EN, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports (one clock; reset is synchronous and active-low):
- i_riscv_arb_clk  in  1  clock; all logic on rising edge.
- i_riscv_arb_rst  in  1  synchronous active-low reset.
- i_riscv_arb_req  in  NUM_CH  per-channel request; held high until matching ack.
- i_riscv_arb_we  in  NUM_CH  per-channel write (1) / read (0).
- i_riscv_arb_addr  in  NUM_CH*ADDR_W  per-channel address, channel k at bits [k*ADDR_W +: ADDR_W].
- i_riscv_arb_wdata  in  NUM_CH*LINE_W  per-channel write line, same packing.
- o_riscv_arb_ack  out  NUM_CH  one-cycle completion pulse, one-hot.
- o_riscv_arb_rdata  out  LINE_W  read line, valid in the ack cycle of a read.
- o_riscv_arb_busy  out  1  high while a transaction is owned.
- o_riscv_arb_mem_req  out  1  memory request.
- o_riscv_arb_mem_we  out  1  memory write enable.
- o_riscv_arb_mem_addr  out  ADDR_W  memory address.
- o_riscv_arb_mem_wdata  out  LINE_W  memory write line.
- i_riscv_arb_mem_ready  in  1  memory completion, single cycle.
- i_riscv_arb_mem_rdata  in  LINE_W  memory read line, valid with ready.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req is high, select the winner, latch its index, we, addr and wdata into the mem_* output registers, then go to BUSY. Otherwise stay in IDLE.
- BUSY: mem_req = 1 with mem_we/addr/wdata held stable. On mem_ready: capture mem_rdata into o_rdata if the transaction is a read, then go to DONE. Writes leave o_rdata unchanged.
- DONE: ack[owner] = 1 for exactly one cycle, mem_req = 0, update the arbitration pointer, then go to IDLE.
- Fixed priority: the lowest-index asserted req wins.
- Round-robin: search starts at pointer, ascending, wrapping from NUM_CH-1 to 0. After completion of channel k, pointer = (k+1) mod NUM_CH. The pointer updates only in DONE.
- Requests arriving during BUSY/DONE wait; no queueing beyond the held req lines.
- Dropping req before ack is a protocol violation: the arbiter completes the transaction and still pulses ack.
- busy = 1 in BUSY and DONE.
- Reset values: state IDLE, pointer 0, ack 0, rdata 0, busy 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset asserted mid-transaction: the above values apply on the next edge. The in-flight transaction is abandoned with no ack, and mem_req drops.

## Timing
- Req sampled high in IDLE at cycle 0 → mem_req high from cycle 1.
- mem_ready at cycle n (n≥1) → ack at cycle n+1 → IDLE at n+2.
- Minimum req-to-ack is 2 cycles, with 3 cycles occupancy per transaction. Back-to-back grants are therefore separated by one IDLE cycle.
- The requester drops req (or presents a new request) in the cycle after ack. A req still high in the IDLE cycle is treated as a new request.
- mem_ready outside BUSY is ignored.
- Simultaneous requests: exactly one winner per IDLE cycle. No combinational path from i_* to o_*.

## Test plan
- Single read: ch1 req, addr 0x80, mem_ready 3 cycles after mem_req with rdata 0xDEAD…BEEF → mem_addr 0x80, mem_we 0, ack = 2'b10 one cycle later, o_rdata = 0xDEAD…BEEF.
- Fixed priority (RR_EN=0): ch0 and ch1 held high continuously, ready after 1 cycle each time → ch0 granted every time; ch1 starves until ch0 drops.
- Round-robin (RR_EN=1, NUM_CH=4): all four reqs held → grant order 0,1,2,3,0. Ack spacing is 3 cycles with immediate ready.
- Write: ch0 we=1, wdata 0x1234… → mem_we 1, mem_wdata matches, ack pulses, o_rdata unchanged from its prior value.
- Reset mid-BUSY: rst low while mem_req is high → next edge mem_req 0, busy 0, no ack. After release, a pending req is re-arbitrated with pointer 0.
- Stray ready: mem_ready pulsed in IDLE → no state change, no ack.
